// File: rtl/prod_acc.sv
// Product accumulator: sums 32-bit unsigned product beats into an ACC_W-bit total.
// It holds each completed sum until the consumer takes it. Define PROD_ACC_SAT_EN to clamp on overflow instead of wrapping.
module prod_acc #(
  parameter int unsigned ACC_W = 40,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_prod,
  input  logic             in_last,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             ovf
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf_q;

  logic             accept;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic [ACC_W-1:0] acc_add;

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign out_acc   = acc;
  assign out_count = cnt;
  assign ovf       = ovf_q;

  assign accept = in_valid & in_ready;

  always_comb begin
    sum   = {1'b0, acc} + {{(ACC_W - 31){1'b0}}, in_prod};
    carry = sum[ACC_W];
`ifdef PROD_ACC_SAT_EN
    // Once clamped at all-ones, any further non-zero beat carries again, so the clamp persists.
    acc_add = carry ? '1 : sum[ACC_W-1:0];
`else
    acc_add = sum[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else if (clr) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc   <= acc_add;
            cnt   <= cnt + CNT_W'(1);
            ovf_q <= ovf_q | carry;
            state <= in_last ? HOLD : ACCUM;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          acc   <= '0;
          cnt   <= '0;
          ovf_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prod_acc.sv
// Bench for prod_acc: directed scenarios plus random traffic against a beat-list reference model.
module tb_prod_acc;

  localparam int unsigned ACC_W = 33;
  localparam int unsigned CNT_W = 4;
  localparam logic [63:0] LIM   = 64'd1 << ACC_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_prod;
  logic             in_last;
  logic             clr;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;
  logic             ovf;

  int checks   = 0;
  int failures = 0;

  logic [63:0] beats[$];
  bit          m_hold;

  prod_acc #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_count (out_count),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] m_total();
    logic [63:0] t = '0;
    foreach (beats[i]) t += beats[i];
    return t;
  endfunction

  function automatic logic [63:0] m_acc();
    logic [63:0] t = m_total();
`ifdef PROD_ACC_SAT_EN
    return (t >= LIM) ? LIM - 64'd1 : t;
`else
    return t % LIM;
`endif
  endfunction

  task automatic check_model(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'(m_hold));
    check({tag, "_in_ready"},  64'(in_ready),  64'(!m_hold));
    check({tag, "_acc"},       64'(out_acc),   m_acc());
    check({tag, "_count"},     64'(out_count), 64'(beats.size() % (1 << CNT_W)));
    check({tag, "_ovf"},       64'(ovf),       64'(m_total() >= LIM));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then compare.
  task automatic cycle(input string tag, input bit v, input logic [31:0] p,
                       input bit l, input bit r, input bit c);
    in_valid  = v;
    in_prod   = p;
    in_last   = l;
    out_ready = r;
    clr       = c;
    @(posedge clk);
    if (c) begin
      beats.delete();
      m_hold = 1'b0;
    end else if (m_hold) begin
      if (r) begin
        beats.delete();
        m_hold = 1'b0;
      end
    end else if (v) begin
      beats.push_back(64'(p));
      if (l) m_hold = 1'b1;
    end
    #1;
    check_model(tag);
  endtask

  initial begin
    logic [63:0] snap_acc;
    rst_n = 1'b0; in_valid = 1'b0; in_prod = '0; in_last = 1'b0;
    clr = 1'b0; out_ready = 1'b0;
    beats.delete();
    m_hold = 1'b0;

    #2;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_acc",       64'(out_acc),   64'd0);
    check("rst_count",     64'(out_count), 64'd0);
    check("rst_ovf",       64'(ovf),       64'd0);
    rst_n = 1'b1;

    // Single beat
    cycle("single", 1, 32'd15000, 1, 0, 0);
    check("single_acc_const", 64'(out_acc), 64'd15000);
    check("single_cnt_const", 64'(out_count), 64'd1);
    cycle("single_take", 0, '0, 0, 1, 0);

    // Three beats
    cycle("three_b0", 1, 32'd4294836225, 0, 0, 0);
    cycle("three_b1", 1, 32'd2254320,    0, 0, 0);
    cycle("three_b2", 1, 32'd0,          1, 0, 0);
    check("three_acc_const", 64'(out_acc), 64'd4297090545);
    check("three_cnt_const", 64'(out_count), 64'd3);
    check("three_ovf_const", 64'(ovf), 64'd0);

    // Backpressure: beats offered while holding must be refused
    snap_acc = 64'(out_acc);
    for (int i = 0; i < 5; i++) begin
      cycle("bp_hold", 1, 32'd77, 1, 0, 0);
      check("bp_acc_stable", 64'(out_acc), snap_acc);
    end
    cycle("bp_release", 0, '0, 0, 1, 0);
    check("bp_idle_valid", 64'(out_valid), 64'd0);

    // Overflow of a 33-bit accumulator after the third maximal product
    cycle("ovf_b0", 1, 32'd4294836225, 0, 0, 0);
    cycle("ovf_b1", 1, 32'd4294836225, 0, 0, 0);
    check("ovf_not_yet", 64'(ovf), 64'd0);
    cycle("ovf_b2", 1, 32'd4294836225, 1, 0, 0);
    check("ovf_flag_const", 64'(ovf), 64'd1);
`ifdef PROD_ACC_SAT_EN
    check("ovf_acc_const", 64'(out_acc), 64'd8589934591);
`else
    check("ovf_acc_const", 64'(out_acc), 64'd4294574083);
`endif
    cycle("ovf_take", 0, '0, 0, 1, 0);

    // Clear during accumulation, colliding with an accepted beat
    cycle("clr_b0", 1, 32'd1234, 0, 0, 0);
    cycle("clr_hit", 1, 32'd999, 1, 0, 1);
    check("clr_acc_const", 64'(out_acc), 64'd0);
    check("clr_valid_const", 64'(out_valid), 64'd0);
    cycle("clr_next", 1, 32'd1, 1, 0, 0);
    check("clr_next_acc_const", 64'(out_acc), 64'd1);
    check("clr_next_cnt_const", 64'(out_count), 64'd1);

    // Asynchronous reset while holding a result
    check("arst_pre_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_acc",   64'(out_acc),   64'd0);
    check("arst_ready", 64'(in_ready),  64'd1);
    beats.delete();
    m_hold = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle("arst_resume", 1, 32'd42, 0, 0, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] p;
      case ($urandom_range(0, 3))
        0:       p = 32'd0;
        1:       p = 32'hFFFF_FFFF - 32'($urandom_range(0, 200000));
        2:       p = $urandom;
        default: p = 32'($urandom_range(0, 255));
      endcase
      cycle("rand", $urandom_range(0, 3) != 0, p, $urandom_range(0, 11) == 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
